// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_INPUTS AXI-Stream slaves share one master port.
// The grant is held for a whole tlast-delimited packet, then priority rotates past the winner.
module axis_rr_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 2
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUM_INPUTS-1:0]            s_tvalid,
    output logic [NUM_INPUTS-1:0]            s_tready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_INPUTS-1:0]            s_tlast,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic                             m_tlast,
    output logic [ID_WIDTH-1:0]              m_tid
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_INPUTS - 1);

    state_t              state;
    state_t              state_next;
    logic [ID_WIDTH-1:0] sel;
    logic [ID_WIDTH-1:0] sel_next;
    logic [ID_WIDTH-1:0] last_grant;
    logic [ID_WIDTH-1:0] last_grant_next;
    logic [ID_WIDTH-1:0] winner;
    logic                any_req;
    logic                locked;
    logic                xfer;
    logic                grant_valid;
    logic                grant_last;
    logic [DATA_WIDTH-1:0] grant_data;

    // Search starts one past ptr and wraps at NUM_INPUTS-1, so non-power-of-two
    // sizes never produce an out-of-range index.
    function automatic logic [ID_WIDTH-1:0] rr_pick(
        input logic [NUM_INPUTS-1:0] req,
        input logic [ID_WIDTH-1:0]   ptr
    );
        logic [ID_WIDTH-1:0] pick;
        logic                found;
        int                  idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
            for (int j = 0; j < NUM_INPUTS; j++) begin
                if (!found && (j == idx) && req[j]) begin
                    pick  = ID_WIDTH'(j);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

    assign any_req = |s_tvalid;
    assign winner  = rr_pick(s_tvalid, last_grant);

    always_comb begin
        grant_valid = 1'b0;
        grant_data  = '0;
        grant_last  = 1'b0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
            if (sel == ID_WIDTH'(j)) begin
                grant_valid = s_tvalid[j];
                grant_data  = s_tdata[j*DATA_WIDTH +: DATA_WIDTH];
                grant_last  = s_tlast[j];
            end
        end
    end

    // Gating with aresetn forces every output low the moment reset asserts.
    assign locked   = aresetn && (state == LOCKED);
    assign m_tvalid = locked && grant_valid;
    assign m_tdata  = locked ? grant_data : '0;
    assign m_tlast  = locked && grant_last;
    assign m_tid    = locked ? sel : '0;
    assign xfer     = m_tvalid && m_tready;

    always_comb begin
        s_tready = '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
            if (locked && (sel == ID_WIDTH'(j))) s_tready[j] = m_tready;
        end
    end

    always_comb begin
        state_next      = state;
        sel_next        = sel;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (any_req) begin
                    sel_next   = winner;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                // Gaps in s_tvalid keep the lock; only a tlast transfer releases it.
                if (xfer && grant_last) begin
                    last_grant_next = sel;
                    state_next      = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            sel        <= '0;
            last_grant <= LAST_IDX;
        end else begin
            state      <= state_next;
            sel        <= sel_next;
            last_grant <= last_grant_next;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: cycle tables, reset/wrap sequences and a randomized
// per-source scoreboard run on a 4-input instance plus a 3-input instance.
module tb_axis_rr_arbiter;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        aresetn;
    logic [3:0]  s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [7:0]  m_tdata;
    logic [1:0]  m_tid;

    logic [2:0]  s3_tvalid, s3_tready, s3_tlast;
    logic [23:0] s3_tdata;
    logic        m3_tvalid, m3_tready, m3_tlast;
    logic [7:0]  m3_tdata;
    logic [1:0]  m3_tid;

    axis_rr_arbiter #(.NUM_INPUTS(4), .DATA_WIDTH(8), .ID_WIDTH(2)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_tid(m_tid)
    );

    axis_rr_arbiter #(.NUM_INPUTS(3), .DATA_WIDTH(8), .ID_WIDTH(2)) dut3 (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s3_tvalid), .s_tready(s3_tready), .s_tdata(s3_tdata), .s_tlast(s3_tlast),
        .m_tvalid(m3_tvalid), .m_tready(m3_tready), .m_tdata(m3_tdata), .m_tlast(m3_tlast),
        .m_tid(m3_tid)
    );

    typedef struct packed {
        logic        rst;
        logic [3:0]  vld;
        logic [31:0] data;
        logic [3:0]  last;
        logic        rdy;
        logic        e_vld;
        logic [7:0]  e_data;
        logic        e_last;
        logic [1:0]  e_tid;
        logic [3:0]  e_rdy;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [8:0] exp_q [4][$];
    logic       acc [4];
    logic       cv [4];
    logic       active [4];
    logic       cl [4];
    logic [7:0] cd [4];
    int         rem [4];
    int         seqn [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic void add(input logic r, input logic [3:0] vl, input logic [31:0] d,
                                input logic [3:0] l, input logic rd, input logic ev,
                                input logic [7:0] ed, input logic el, input logic [1:0] et,
                                input logic [3:0] er);
        vec_t v;
        v.rst = r; v.vld = vl; v.data = d; v.last = l; v.rdy = rd;
        v.e_vld = ev; v.e_data = ed; v.e_last = el; v.e_tid = et; v.e_rdy = er;
        vecs.push_back(v);
    endfunction

    task automatic pulse_reset();
        aresetn = 1'b0;
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic xfer, in_pkt, done;
        logic [1:0] pkt_src;
        logic [8:0] got, want;

        aresetn = 1'b0;
        s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 1'b1;
        s3_tvalid = '0; s3_tdata = '0; s3_tlast = '0; m3_tready = 1'b1;
        #2;
        check("reset m_tvalid", m_tvalid, 0);
        check("reset s_tready", s_tready, 0);
        repeat (3) tick();
        aresetn = 1'b1;

        // Idle: nothing requested for 10 cycles.
        add(1, 4'b0000, 32'h0, 4'b0, 1, 0, 8'h0, 0, 0, 4'b0);
        for (int i = 0; i < 9; i++) add(0, 4'b0000, 32'h0, 4'b0, 1, 0, 8'h0, 0, 0, 4'b0);
        // Inputs 1 and 3 each offer a 3-beat packet.
        add(1, 4'b1010, 32'h30001000, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000);
        add(0, 4'b1010, 32'h30001000, 4'b0000, 1, 1, 8'h10, 0, 1, 4'b0010);
        add(0, 4'b1010, 32'h30001100, 4'b0000, 1, 1, 8'h11, 0, 1, 4'b0010);
        add(0, 4'b1010, 32'h30001200, 4'b0010, 1, 1, 8'h12, 1, 1, 4'b0010);
        add(0, 4'b1000, 32'h30000000, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000);
        add(0, 4'b1000, 32'h30000000, 4'b0000, 1, 1, 8'h30, 0, 3, 4'b1000);
        add(0, 4'b1000, 32'h31000000, 4'b0000, 1, 1, 8'h31, 0, 3, 4'b1000);
        add(0, 4'b1000, 32'h32000000, 4'b1000, 1, 1, 8'h32, 1, 3, 4'b1000);
        add(0, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000);
        // All four inputs continuously offer single-beat packets.
        add(1, 4'b1111, 32'h03020100, 4'b1111, 1, 0, 8'h00, 0, 0, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            add(0, 4'b1111, 32'h03020100, 4'b1111, 1, 1, 8'(i % 4), 1, 2'(i % 4), 4'(1 << (i % 4)));
            add(0, 4'b1111, 32'h03020100, 4'b1111, 1, 0, 8'h00, 0, 0, 4'b0000);
        end
        // Input 2 locked with stalls and valid gaps while input 0 waits.
        add(1, 4'b0100, 32'h00200000, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000);
        add(0, 4'b0101, 32'h00200005, 4'b0001, 1, 1, 8'h20, 0, 2, 4'b0100);
        add(0, 4'b0101, 32'h00210005, 4'b0001, 0, 1, 8'h21, 0, 2, 4'b0000);
        add(0, 4'b0101, 32'h00210005, 4'b0001, 0, 1, 8'h21, 0, 2, 4'b0000);
        add(0, 4'b0101, 32'h00210005, 4'b0001, 1, 1, 8'h21, 0, 2, 4'b0100);
        add(0, 4'b0001, 32'h00220005, 4'b0001, 1, 0, 8'h22, 0, 2, 4'b0100);
        add(0, 4'b0001, 32'h00220005, 4'b0001, 1, 0, 8'h22, 0, 2, 4'b0100);
        add(0, 4'b0101, 32'h00220005, 4'b0101, 1, 1, 8'h22, 1, 2, 4'b0100);
        add(0, 4'b0001, 32'h00000005, 4'b0001, 1, 0, 8'h00, 0, 0, 4'b0000);
        add(0, 4'b0001, 32'h00000005, 4'b0001, 1, 1, 8'h05, 1, 0, 4'b0001);
        add(0, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000);

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            tick();
            if (v.rst) pulse_reset();
            s_tvalid = v.vld; s_tdata = v.data; s_tlast = v.last; m_tready = v.rdy;
            #1;
            check($sformatf("vec%0d m_tvalid", k), m_tvalid, v.e_vld);
            check($sformatf("vec%0d m_tdata", k), m_tdata, v.e_data);
            check($sformatf("vec%0d m_tlast", k), m_tlast, v.e_last);
            check($sformatf("vec%0d m_tid", k), m_tid, v.e_tid);
            check($sformatf("vec%0d s_tready", k), s_tready, v.e_rdy);
        end

        // Reset mid-packet: outputs drop at once and the old grant is not resumed.
        tick();
        pulse_reset();
        s_tvalid = 4'b0100; s_tdata = 32'h00520000; s_tlast = '0; m_tready = 1'b1;
        #1;
        check("midrst idle m_tvalid", m_tvalid, 0);
        tick();
        #1;
        check("midrst locked m_tid", m_tid, 2);
        check("midrst locked m_tvalid", m_tvalid, 1);
        #1;
        aresetn = 1'b0;
        #1;
        check("midrst async m_tvalid", m_tvalid, 0);
        check("midrst async s_tready", s_tready, 0);
        check("midrst async m_tdata", m_tdata, 0);
        check("midrst async m_tid", m_tid, 0);
        s_tvalid = 4'b0110; s_tdata = 32'h00524100;
        tick();
        check("midrst held m_tvalid", m_tvalid, 0);
        aresetn = 1'b1;
        #1;
        check("midrst release idle m_tvalid", m_tvalid, 0);
        tick();
        #1;
        check("midrst regrant m_tid", m_tid, 1);
        check("midrst regrant m_tdata", m_tdata, 8'h41);
        check("midrst regrant s_tready", s_tready, 4'b0010);
        s_tvalid = '0; s_tdata = '0;

        // Three inputs: pointer must wrap from 2 to 0.
        tick();
        pulse_reset();
        s3_tvalid = 3'b100; s3_tdata = 24'hA20000; s3_tlast = 3'b100;
        #1;
        check("n3 idle m_tvalid", m3_tvalid, 0);
        tick();
        s3_tvalid = 3'b111; s3_tdata = 24'hA2A1A0; s3_tlast = 3'b111;
        #1;
        check("n3 grant2 m_tid", m3_tid, 2);
        check("n3 grant2 m_tdata", m3_tdata, 8'hA2);
        check("n3 grant2 s_tready", s3_tready, 3'b100);
        tick();
        s3_tvalid = 3'b011;
        #1;
        check("n3 gap m_tvalid", m3_tvalid, 0);
        tick();
        #1;
        check("n3 wrap m_tid", m3_tid, 0);
        check("n3 wrap m_tdata", m3_tdata, 8'hA0);
        check("n3 wrap s_tready", s3_tready, 3'b001);
        tick();
        s3_tvalid = 3'b010;
        tick();
        #1;
        check("n3 next m_tid", m3_tid, 1);
        s3_tvalid = '0;

        // Randomized traffic with per-source scoreboard.
        tick();
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            acc[i] = 0; cv[i] = 0; active[i] = 0; cl[i] = 0; cd[i] = '0; rem[i] = 0; seqn[i] = 0;
            exp_q[i].delete();
        end
        in_pkt = 0; pkt_src = 0; done = 0;
        for (int cyc = 0; cyc < 7000 && !done; cyc++) begin
            if (cyc > 0) tick();
            for (int i = 0; i < 4; i++) begin
                if (cv[i] && acc[i]) begin
                    cv[i] = 0;
                    rem[i]--;
                    if (rem[i] == 0) active[i] = 0;
                end
                if (!cv[i]) begin
                    if (!active[i] && cyc < 5000 && $urandom_range(0, 3) == 0) begin
                        active[i] = 1;
                        rem[i] = $urandom_range(1, 8);
                    end
                    if (active[i] && $urandom_range(0, 2) != 0) begin
                        cv[i] = 1;
                        cd[i] = {i[1:0], seqn[i][5:0]};
                        seqn[i]++;
                        cl[i] = (rem[i] == 1);
                        exp_q[i].push_back({cl[i], cd[i]});
                    end
                end
                s_tvalid[i] = cv[i];
                s_tlast[i] = cl[i];
                s_tdata[i*8 +: 8] = cd[i];
            end
            m_tready = (cyc >= 5000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            check("rnd s_tready onehot0", $onehot0(s_tready), 1);
            xfer = m_tvalid && m_tready;
            for (int i = 0; i < 4; i++) begin
                acc[i] = s_tvalid[i] && s_tready[i];
                check($sformatf("rnd handshake src%0d", i), acc[i], xfer && (m_tid == 2'(i)));
            end
            if (xfer) begin
                if (in_pkt) check("rnd no interleave", m_tid, pkt_src);
                if (exp_q[m_tid].size() == 0) begin
                    check("rnd unexpected beat", 1, 0);
                end else begin
                    want = exp_q[m_tid].pop_front();
                    got = {m_tlast, m_tdata};
                    check($sformatf("rnd beat src%0d", m_tid), got, want);
                end
                in_pkt = !m_tlast;
                pkt_src = m_tid;
            end
            if (cyc >= 5000) begin
                done = 1;
                for (int i = 0; i < 4; i++)
                    if (active[i] || cv[i] || exp_q[i].size() != 0) done = 0;
            end
        end
        check("rnd drain complete", done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
